gcm_tag_check: RTL
==================

GCM_TAG_CHECK -- requirements
Module: gcm_tag_check

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: i_start  in  1  single-cycle pulse that begins a message check.
REQ-004 SHALL have ports: i_h  in  [0:127]  hash subkey H = E(K,0^128); sampled on accepted i_start.
REQ-005 SHALL have ports: i_ek_j0  in  [0:127]  E(K,J0); sampled on accepted i_start.
REQ-006 SHALL have ports: i_len_block  in  [0:127]  len(A)||len(C) in bits; sampled on accepted i_start.
REQ-007 SHALL have ports: i_tag  in  [0:127]  received tag; sampled on accepted i_start.
REQ-008 SHALL have ports: i_data  in  [0:127]  AAD or ciphertext block, zero-padded by sender.
REQ-009 SHALL have ports: i_data_valid  in  1  block valid; i_data_last  in  1  final block marker.
REQ-010 SHALL have ports: o_data_ready  out  1  block accepted when valid and ready are both high at a clk edge.
REQ-011 SHALL have ports: o_busy  out  1  high in any state other than IDLE.
REQ-012 SHALL have ports: o_done  out  1  one-cycle pulse when the result is valid.
REQ-013 SHALL have ports: o_tag_ok  out  1  computed tag equals i_tag; held until next accepted i_start.
REQ-014 SHALL have ports: o_tag  out  [0:127]  computed tag; held until next accepted i_start.

Function
REQ-015 SHALL use bit 0 as the GCM leftmost, most significant bit on all 128-bit buses.
REQ-016 SHALL implement the FSM states IDLE, WAIT_DATA, MULT, LEN_MULT, FINAL, DONE.
REQ-017 IDLE: on i_start SHALL latch all four sampled inputs, clear accumulator X, and go to WAIT_DATA; if i_len_block==0 it SHALL go to LEN_MULT instead.
REQ-018 WAIT_DATA: SHALL drive o_data_ready=1; on an accepted block SHALL set X<=X^i_data, latch i_data_last, and go to MULT.
REQ-019 o_data_ready SHALL be 0 in every state except WAIT_DATA; i_data_valid outside WAIT_DATA SHALL be ignored.
REQ-020 MULT and LEN_MULT SHALL compute X<=X*H in GF(2^128): Z=0, V=H; per step i, if X[i] then Z^=V; V=V>>1, XORed with E1||0^120 when the shifted-out bit V[127] was 1.
REQ-021 Multiply steps SHALL be processed serially from a counter; with 1 step per cycle a multiply SHALL take exactly 128 cycles.
REQ-022 At the end of MULT: if last was latched, SHALL set X<=Z^len_block and go to LEN_MULT; otherwise SHALL set X<=Z and return to WAIT_DATA.
REQ-023 At the end of LEN_MULT SHALL set X<=Z and go to FINAL.
REQ-024 FINAL: SHALL register o_tag<=X^ek_j0 and o_tag_ok<=(full 128-bit equality with the latched tag), then go to DONE.
REQ-025 DONE: SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-026 i_start while o_busy=1 SHALL be ignored.
REQ-027 A 0-to-1 transition on i_data_last without i_data_valid SHALL have no effect.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately force IDLE and clear X, Z, V, and the counter, including mid-multiply.
REQ-029 Reset values SHALL be: o_data_ready=0, o_busy=0, o_done=0, o_tag_ok=0, o_tag=0.

Configuration
REQ-030 When GCM_MULT_PAR4_EN is defined, the block SHALL process 4 multiply steps per cycle, taking 32 cycles per multiply, with identical results.
REQ-031 When GCM_MULT_PAR4_EN is undefined, the block SHALL process 1 step per cycle, taking 128 cycles per multiply.
REQ-032 All other timing SHALL be unchanged by GCM_MULT_PAR4_EN.

Verification
REQ-033 Empty message: i_h=66e94bd4ef8a2c3b884cfa59ca342b2e, i_ek_j0=58e2fccefa7e3061367f1d57a4e7455a, len=0, i_tag=58e2fccefa7e3061367f1d57a4e7455a -> o_tag equals i_ek_j0, o_tag_ok=1, no o_data_ready.
REQ-034 One block: same H/EK(J0), len=000...0080, data=0388dace60b6a392f328c2b971b2fe78 with last=1, tag=ab6e47d42cec13bdf53a67b21257bddf -> o_tag_ok=1, o_done 128+128+2 cycles after acceptance (32+32+2 with the macro defined).
REQ-035 Same as REQ-034 with tag bit 127 flipped -> o_tag=ab6e...bddf, o_tag_ok=0.
REQ-036 Two blocks with valid gaps of 5 cycles, plus i_start pulses during MULT -> ready only in WAIT_DATA; the stray starts have no effect; result matches the software model.
REQ-037 i_rst_n low for 1 cycle at step 60 of MULT -> all outputs at reset values; a fresh REQ-034 run afterwards passes.

Source files
------------

// File: rtl/gcm_tag_check.sv
// ---------------------------------------------------------------------------
// gcm_tag_check
//
// Purpose
//   Recomputes the AES-GCM authentication tag for one message and compares it
//   against a received tag. The caller supplies the hash subkey H, E(K,J0),
//   the length block len(A)||len(C) and the received tag with a start pulse.
//   It then streams the zero-padded AAD/ciphertext blocks. Each block is folded
//   into the GHASH accumulator X and multiplied by H in GF(2^128). The length
//   block is folded in last. The final X is masked with E(K,J0) to form the tag.
//
//   All 128-bit buses use [0:127] ordering. Bit 0 is the leftmost, most
//   significant GCM bit. With this ordering the GCM "right shift" maps
//   directly onto the SystemVerilog >> operator.
//
// Ports
//   clk            in   sole clock, rising edge
//   i_rst_n        in   asynchronous assert, active-low reset
//   i_start        in   one-cycle pulse that begins a check (ignored while busy)
//   i_h            in   [0:127] hash subkey H, sampled on accepted start
//   i_ek_j0        in   [0:127] E(K,J0), sampled on accepted start
//   i_len_block    in   [0:127] len(A)||len(C) in bits, sampled on accepted start
//   i_tag          in   [0:127] received tag, sampled on accepted start
//   i_data         in   [0:127] AAD or ciphertext block
//   i_data_valid   in   block valid
//   i_data_last    in   final block marker, qualified by i_data_valid
//   o_data_ready   out  high only while waiting for a data block
//   o_busy         out  high in every state except IDLE
//   o_done         out  one-cycle pulse when o_tag / o_tag_ok are valid
//   o_tag_ok       out  computed tag equals received tag (held)
//   o_tag          out  [0:127] computed tag (held)
//
// Configuration
//   GCM_MULT_PAR4_EN  when defined, the GF(2^128) multiplier retires 4 steps
//                     per cycle (32 cycles per multiply) instead of 1 step per
//                     cycle (128 cycles per multiply). Results and all other
//                     timing are identical.
// ---------------------------------------------------------------------------
module gcm_tag_check (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [0:127] i_h,
    input  logic [0:127] i_ek_j0,
    input  logic [0:127] i_len_block,
    input  logic [0:127] i_tag,
    input  logic [0:127] i_data,
    input  logic         i_data_valid,
    input  logic         i_data_last,
    output logic         o_data_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_tag_ok,
    output logic [0:127] o_tag
);

`ifdef GCM_MULT_PAR4_EN
    localparam int STEPS = 4;
`else
    localparam int STEPS = 1;
`endif
    localparam int               MUL_CYCLES = 128 / STEPS;
    localparam int               CNT_W      = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MUL_CYCLES - 1);

    // Reduction constant R = 11100001 || 0^120, in GCM bit order.
    localparam logic [0:127] GF_R = {8'he1, 120'h0};

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DATA = 3'd1;
    localparam logic [2:0] ST_MULT      = 3'd2;
    localparam logic [2:0] ST_LEN_MULT  = 3'd3;
    localparam logic [2:0] ST_FINAL     = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [0:127]     h_q,       h_d;
    logic [0:127]     ek_q,      ek_d;
    logic [0:127]     len_q,     len_d;
    logic [0:127]     exp_tag_q, exp_tag_d;
    logic [0:127]     x_q,       x_d;
    logic [0:127]     z_q,       z_d;
    logic [0:127]     v_q,       v_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             last_q,    last_d;
    logic [0:127]     tag_q,     tag_d;
    logic             tag_ok_q,  tag_ok_d;

    // Multiplier result after this cycle's steps.
    logic [0:127]     z_step;
    logic [0:127]     v_step;
    logic [0:127]     final_tag;

    // -----------------------------------------------------------------------
    // GF(2^128) multiply steps for one cycle.
    // During a multiply, x_q is consumed from bit 0 and shifted toward
    // bit 0 by STEPS each cycle. Bit k of x_q is therefore the operand bit
    // for step k of the current cycle. X itself is rewritten with the product
    // at the end of the multiply. Destroying the operand copy is harmless.
    // -----------------------------------------------------------------------
    always_comb begin
        z_step = z_q;
        v_step = v_q;
        for (int k = 0; k < STEPS; k++) begin
            if (x_q[k]) begin
                z_step = z_step ^ v_step;
            end
            // Bit 127 is the bit shifted out; fold it back with R.
            v_step = (v_step >> 1) ^ (v_step[127] ? GF_R : '0);
        end
    end

    assign final_tag = x_q ^ ek_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        ek_d      = ek_q;
        len_d     = len_q;
        exp_tag_d = exp_tag_q;
        x_d       = x_q;
        z_d       = z_q;
        v_d       = v_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tag_d     = tag_q;
        tag_ok_d  = tag_ok_q;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    h_d       = i_h;
                    ek_d      = i_ek_j0;
                    len_d     = i_len_block;
                    exp_tag_d = i_tag;
                    x_d       = '0;
                    z_d       = '0;
                    v_d       = i_h;
                    cnt_d     = '0;
                    last_d    = 1'b0;
                    // An all-zero length block means no AAD and no
                    // ciphertext. Only the length block is hashed.
                    state_d   = (i_len_block == '0) ? ST_LEN_MULT : ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                // i_data_last is only meaningful together with i_data_valid.
                if (i_data_valid) begin
                    x_d     = x_q ^ i_data;
                    last_d  = i_data_last;
                    z_d     = '0;
                    v_d     = h_q;
                    cnt_d   = '0;
                    state_d = ST_MULT;
                end
            end

            ST_MULT, ST_LEN_MULT: begin
                z_d   = z_step;
                v_d   = v_step;
                x_d   = x_q << STEPS;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // The product is complete. Reload the multiplier so it
                    // is ready for the next multiply.
                    cnt_d = '0;
                    z_d   = '0;
                    v_d   = h_q;
                    if (state_q == ST_LEN_MULT) begin
                        x_d     = z_step;
                        state_d = ST_FINAL;
                    end else if (last_q) begin
                        x_d     = z_step ^ len_q;
                        state_d = ST_LEN_MULT;
                    end else begin
                        x_d     = z_step;
                        state_d = ST_WAIT_DATA;
                    end
                end
            end

            ST_FINAL: begin
                tag_d    = final_tag;
                tag_ok_d = (final_tag == exp_tag_q);
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            h_q       <= '0;
            ek_q      <= '0;
            len_q     <= '0;
            exp_tag_q <= '0;
            x_q       <= '0;
            z_q       <= '0;
            v_q       <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tag_q     <= '0;
            tag_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            ek_q      <= ek_d;
            len_q     <= len_d;
            exp_tag_q <= exp_tag_d;
            x_q       <= x_d;
            z_q       <= z_d;
            v_q       <= v_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tag_q     <= tag_d;
            tag_ok_q  <= tag_ok_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs, decoded from registered state
    // -----------------------------------------------------------------------
    assign o_data_ready = (state_q == ST_WAIT_DATA);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_tag_ok     = tag_ok_q;
    assign o_tag        = tag_q;

endmodule
